// File: rtl/usf_pkg.sv
// -----------------------------------------------------------------------------
// usf_pkg -- definitions shared by diff_operator and antidiff_operator.
//
// Contents:
//   SAMPLE_W    : sample width in bits (16)
//   sample_t    : signed two's-complement sample type
//   sub_wrap()  : a - b, modulo 2^SAMPLE_W
//   sub_sat()   : a - b, clamped to [-32768, 32767]
//
// Configuration: the sub_sat() helper is used by diff_stage only when
// DIFF_OPERATOR_SAT_EN is defined; it costs nothing when unused.
// -----------------------------------------------------------------------------
package usf_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Largest and smallest representable samples.
  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  // Plain modulo-2^16 difference.
  function automatic sample_t sub_wrap(input sample_t a, input sample_t b);
    sub_wrap = a - b;
  endfunction

  // Difference computed one bit wider, then clamped. Overflow shows up as the
  // two top bits of the wide result disagreeing; the top bit gives the sign
  // of the true result and thus which rail to clamp to.
  function automatic sample_t sub_sat(input sample_t a, input sample_t b);
    logic signed [SAMPLE_W:0] wide;
    wide = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
    if (wide[SAMPLE_W] != wide[SAMPLE_W-1]) begin
      if (wide[SAMPLE_W] == 1'b0) begin
        sub_sat = SAMPLE_MAX;
      end else begin
        sub_sat = SAMPLE_MIN;
      end
    end else begin
      sub_sat = wide[SAMPLE_W-1:0];
    end
  endfunction

endpackage : usf_pkg

// File: rtl/diff_operator_stage.sv
// -----------------------------------------------------------------------------
// diff_stage -- one first-difference stage: d_o = d_i - p, where p is the
// previous enabled-edge value of d_i.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears p
//   en    : sample strobe; p captures d_i on enabled edges
//   d_i   : stage input sample (combinational from the previous stage)
//   d_o   : stage output difference (combinational)
//
// Configuration: DIFF_OPERATOR_SAT_EN selects a saturating subtract instead
// of modulo-2^16 wrap.
// -----------------------------------------------------------------------------
module diff_stage
  import usf_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  sample_t d_i,
  output sample_t d_o
);

  sample_t p_q;
  sample_t p_d;

  // Subtract the stored previous input from the current one.
`ifdef DIFF_OPERATOR_SAT_EN
  assign d_o = sub_sat(d_i, p_q);
`else
  assign d_o = sub_wrap(d_i, p_q);
`endif

  // Previous-input capture: only enabled edges advance the history.
  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = d_i;
    end else begin
      p_d = p_q;
    end
  end

  // History register; reset restores zero history.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= 16'sh0000;
    end else begin
      p_q <= p_d;
    end
  end

endmodule : diff_stage

// File: rtl/diff_operator.sv
// -----------------------------------------------------------------------------
// diff_operator -- order-th finite difference of a 16-bit sample stream.
//
// Parameters:
//   order      : number of cascaded first-difference stages (1..2^order_bits-1)
//   order_bits : width of the warm-up counter
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset (wins over en)
//   en    : sample strobe, one sample per enabled edge
//   y     : input sample, two's complement
//   out   : registered order-th difference, valid one clock after the edge
//   valid : high once out no longer depends on the zero start-up history
//
// Configuration: define DIFF_OPERATOR_SAT_EN to saturate each stage result to
// [-32768, 32767]; by default every stage wraps modulo 2^16 so that an
// antidiff_operator of the same order reconstructs y exactly.
// -----------------------------------------------------------------------------
module diff_operator
  import usf_pkg::*;
#(
  parameter int order      = 2,
  parameter int order_bits = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] y,
  output logic [SAMPLE_W-1:0] out,
  output logic                valid
);

  localparam logic [order_bits-1:0] ORDER_C = order[order_bits-1:0];

  // d_chain[0] is the raw sample, d_chain[k] is the k-th difference.
  sample_t d_chain [order+1];

  logic [SAMPLE_W-1:0]   out_q;
  logic [SAMPLE_W-1:0]   out_d;
  logic                  valid_q;
  logic                  valid_d;
  logic [order_bits-1:0] cnt_q;
  logic [order_bits-1:0] cnt_d;

  assign d_chain[0] = sample_t'(y);

  for (genvar k = 1; k <= order; k++) begin : g_stage
    diff_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d_i   (d_chain[k-1]),
      .d_o   (d_chain[k])
    );
  end

  // Next-state for out, valid and the warm-up counter. valid looks at the
  // pre-edge count, so the first valid output is sample index 'order'.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (en) begin
      out_d   = d_chain[order];
      valid_d = (cnt_q == ORDER_C);
      if (cnt_q != ORDER_C) begin
        cnt_d = cnt_q + {{(order_bits-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      out_d   = out_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
    end
  end

  // Output and warm-up registers; reset discards any coincident sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= {order_bits{1'b0}};
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule : diff_operator

// File: tb/tb_diff_operator.sv
// -----------------------------------------------------------------------------
// tb_diff_operator -- self-checking bench for diff_operator. Two instances
// (order 2 and order 1) share clk/reset/en/y. The expected output is the
// binomial form of the n-th difference over the sample history since reset
// (wrap build) or a level-by-level clamped difference table (saturating build).
// -----------------------------------------------------------------------------
module tb_diff_operator;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] y;
  logic [15:0] out2;
  logic        valid2;
  logic [15:0] out1;
  logic        valid1;

  int n_tests;
  int n_fail;
  int hist[$];   // signed samples accepted since the last reset

  diff_operator #(.order(2), .order_bits(2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .y(y), .out(out2), .valid(valid2)
  );

  diff_operator #(.order(1), .order_bits(2)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .y(y), .out(out1), .valid(valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  // Expected order-th difference of the history (zero before the first sample).
  function automatic logic [15:0] ref_out(input int n_ord, input int h[$]);
    int n;
    logic [31:0] tmp;
    n = h.size();
    if (n == 0) return 16'h0000;
`ifdef DIFF_OPERATOR_SAT_EN
    begin
      int lv[$];
      int nx[$];
      lv = h;
      for (int k = 0; k < n_ord; k++) begin
        nx = {};
        for (int i = 0; i < n; i++)
          nx.push_back(clamp16(lv[i] - ((i > 0) ? lv[i-1] : 0)));
        lv = nx;
      end
      tmp = lv[n-1];
    end
`else
    begin
      int acc;
      int c;
      acc = 0;
      c = 1;
      for (int j = 0; j <= n_ord; j++) begin
        if (n - 1 - j >= 0) acc += ((j % 2 == 0) ? c : -c) * h[n-1-j];
        c = c * (n_ord - j) / (j + 1);
      end
      tmp = acc;
    end
`endif
    return tmp[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model for the current history.
  task automatic check_all(input string tag);
    chk({tag, "_out2"},   out2, ref_out(2, hist));
    chk({tag, "_valid2"}, {15'd0, valid2}, {15'd0, (hist.size() > 2)});
    chk({tag, "_out1"},   out1, ref_out(1, hist));
    chk({tag, "_valid1"}, {15'd0, valid1}, {15'd0, (hist.size() > 1)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    hist  = {};
  endtask

  task automatic do_sample(input logic [15:0] v);
    @(negedge clk);
    y  = v;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    hist.push_back(int'($signed(v)));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] seq27 [5];
    logic [15:0] exp27 [5];
    logic        expv27 [5];
    logic [15:0] seq32 [11];
    logic [15:0] hold_out2;
    logic        hold_valid2;
    logic [15:0] s1;
    logic [15:0] s2;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    en    = 1'b0;
    y     = 16'h0000;
    seq27  = '{16'd1, 16'd4, 16'd7, 16'd9, 16'd14};
    exp27  = '{16'd1, 16'd2, 16'd0, 16'hFFFF, 16'd3};
    expv27 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    seq32  = '{16'd1, 16'd4, 16'd7, 16'd9, 16'd14, 16'd10, 16'd4, 16'd8, 16'd10, 16'd20, 16'd30};

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hist  = {};
    chk("reset_out2", out2, 16'h0000);
    chk("reset_valid2", {15'd0, valid2}, 16'h0000);

    // Directed order-2 sequence, en pulsed once per 10 clocks.
    for (int i = 0; i < 5; i++) begin
      do_sample(seq27[i]);
      chk($sformatf("seq_out_%0d", i), out2, exp27[i]);
      chk($sformatf("seq_valid_%0d", i), {15'd0, valid2}, {15'd0, expv27[i]});
      check_all($sformatf("seq_model_%0d", i));
      idle(8);
    end

    // Long idle with y changing: nothing may move.
    hold_out2   = out2;
    hold_valid2 = valid2;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      y = 16'($urandom);
      if (i % 10 == 9) begin
        chk("idle_out2", out2, hold_out2);
        chk("idle_valid2", {15'd0, valid2}, {15'd0, hold_valid2});
        check_all("idle_model");
      end
    end

    // Reset together with en after three samples, then restart.
    do_reset();
    for (int i = 0; i < 3; i++) do_sample(seq27[i]);
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b1;
    y     = 16'h1234;
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    hist  = {};
    chk("rst_en_out2", out2, 16'h0000);
    chk("rst_en_valid2", {15'd0, valid2}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      do_sample(seq27[i]);
      chk($sformatf("restart_out_%0d", i), out2, exp27[i]);
      chk($sformatf("restart_valid_%0d", i), {15'd0, valid2}, {15'd0, expv27[i]});
    end

    // Order 1 boundary: 0x7FFF then 0x8000.
    do_reset();
    do_sample(16'h7FFF);
    chk("edge_first_out1", out1, 16'h7FFF);
    do_sample(16'h8000);
`ifdef DIFF_OPERATOR_SAT_EN
    chk("edge_out1", out1, 16'h8000);
`else
    chk("edge_out1", out1, 16'h0001);
`endif
    check_all("edge_model");

    // en held high for three edges with y=5.
    do_reset();
    @(negedge clk);
    y  = 16'd5;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hist.push_back(5);
      chk($sformatf("hold_out1_%0d", i), out1, (i == 0) ? 16'd5 : 16'd0);
      chk($sformatf("hold_valid1_%0d", i), {15'd0, valid1}, (i == 0) ? 16'd0 : 16'd1);
    end
    en = 1'b0;

`ifndef DIFF_OPERATOR_SAT_EN
    // Round trip: integrate the order-2 output twice, expect the input back.
    do_reset();
    s1 = 16'h0000;
    s2 = 16'h0000;
    for (int i = 0; i < 11; i++) begin
      do_sample(seq32[i]);
      s1 = s1 + out2;
      s2 = s2 + s1;
      chk($sformatf("roundtrip_%0d", i), s2, seq32[i]);
    end
`endif

    // Randomized stream with random gaps, small and full-range values.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (i % 3 == 0) do_sample(16'($urandom));
      else            do_sample(16'($urandom_range(0, 40)));
      check_all($sformatf("rand_%0d", i));
      idle($urandom_range(0, 3));
      if (i == 30) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_diff_operator

// File: doc/diff_operator.md
DIFF_OPERATOR -- requirements
Module: diff_operator

Interface
REQ-001 SHALL have parameter order, default 2, meaning the number of cascaded first-difference stages (1..2^order_bits-1).
REQ-002 SHALL have parameter order_bits, default 2, meaning the width of the warm-up counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, sample strobe; each rising clk edge with en=1 consumes one sample.
REQ-006 SHALL have port y, input, 16, the two's-complement input sample.
REQ-007 SHALL have port out, output, 16, the order-th finite difference of y, two's complement.
REQ-008 SHALL have port valid, output, 1, high when out is free of start-up transient.

Function
REQ-009 SHALL implement stage k (k=1..order) as d_k = d_(k-1) - p_k, with d_0 = y, where p_k is stage k's stored previous input.
REQ-010 SHALL, on an edge with en=1, update every p_k <= d_(k-1) and register out <= d_order, computed from pre-edge p values.
REQ-011 SHALL present out one cycle after the enabled edge, giving latency 1 clk regardless of order.
REQ-012 SHALL hold out, valid, all p_k and the counter unchanged on edges with en=0.
REQ-013 SHALL treat en held high for N consecutive edges as N samples of the then-current y.
REQ-014 SHALL keep a warm-up counter cnt (order_bits wide) that increments on each enabled edge and saturates at order.
REQ-015 SHALL register valid <= (cnt == order) on each enabled edge, so the first valid output is sample index order (0-based).
REQ-016 SHALL, by default, compute each stage modulo 2^16 (wrap), so antidiff_operator with the same order reconstructs y exactly.
REQ-017 SHALL treat p_k = 0 after reset, so pre-valid outputs equal differences against zero history.

Reset
REQ-018 SHALL, on an edge with reset=1, clear out to 0, valid to 0, cnt to 0 and all p_k to 0.
REQ-019 SHALL give reset priority over en when both are high; that sample is discarded.
REQ-020 SHALL, on reset mid-stream, restart warm-up fully; valid stays 0 until order+1 further samples.

Configuration
REQ-021 SHALL, with macro DIFF_OPERATOR_SAT_EN defined, saturate each stage result to [-32768, 32767] instead of wrapping.
REQ-022 SHALL, without DIFF_OPERATOR_SAT_EN, use pure modulo-2^16 arithmetic with no saturation logic synthesized.
REQ-023 SHALL keep port list, latency and valid timing identical in both configurations.

Structure
REQ-024 SHALL take the sample width constant (16) and the signed sample typedef from shared package usf_pkg, which antidiff_operator also uses.
REQ-025 SHALL implement one first-difference stage as sub-module diff_stage (p register, subtract, optional saturation), instantiated order times by generate.
REQ-026 SHALL keep the warm-up counter, valid and out registers in diff_operator, not in diff_stage.

Verification
REQ-027 SHALL cover: order=2, en pulsed once per 10 clk, y=1,4,7,9,14 -> out=1,2,0,0xFFFF,3, with valid=0,0,1,1,1.
REQ-028 SHALL cover: order=1, y=0x7FFF then 0x8000 -> out=0x0001 without the macro, 0x8000 with DIFF_OPERATOR_SAT_EN.
REQ-029 SHALL cover: order=2, reset asserted together with en after sample 3 -> next cycle out=0, valid=0; the following samples restart as in REQ-027.
REQ-030 SHALL cover: en=0 for 50 clk between samples while y changes -> out, valid unchanged throughout.
REQ-031 SHALL cover: en held high 3 edges with y=5, order=1, from reset -> out=5, then 0, then 0; valid=0,1,1.
REQ-032 SHALL cover: round trip with the sequence 1,4,7,9,14,10,4,8,10,20,30 through diff_operator then antidiff_operator, both order=2 (wrap mode) -> reconstructed output equals input at every sample.
